// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the DVI TMDS encoder: control symbols,
// symbol and disparity widths, and a byte popcount.
package tmds_pkg;

    localparam int CNT_W = 5;
    localparam int SYM_W = 10;

    localparam logic [SYM_W-1:0] CTRL_00 = 10'h354;
    localparam logic [SYM_W-1:0] CTRL_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] CTRL_10 = 10'h154;
    localparam logic [SYM_W-1:0] CTRL_11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_channel.sv
// One TMDS channel: transition minimisation (stage 1) followed by DC balancing
// with a running disparity counter and control-symbol insertion (stage 2).
module tmds_channel
    import tmds_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       d,
    input  logic [1:0]       c,
    input  logic             de,
    output logic [SYM_W-1:0] q
);

    logic [3:0]              n1d_s;
    logic                    use_xnor_s;
    logic [8:0]              qm_s;
    logic [8:0]              qm_r;
    logic [3:0]              n1_r;
    logic                    de_r;
    logic [1:0]              c_r;
    logic signed [CNT_W-1:0] cnt_r;
    logic signed [CNT_W-1:0] cnt_nxt_s;
    logic signed [CNT_W-1:0] n1_sx_s;
    logic signed [CNT_W-1:0] bal_s;
    logic [SYM_W-1:0]        q_nxt_s;

    // Stage 1 combinational: XOR/XNOR chain chosen to minimise transitions
    always_comb begin
        n1d_s      = popcount8(d);
        use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (d[0] == 1'b0));
        qm_s       = 9'd0;
        qm_s[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            if (use_xnor_s) begin
                qm_s[i] = ~(qm_s[i-1] ^ d[i]);
            end else begin
                qm_s[i] = qm_s[i-1] ^ d[i];
            end
        end
        qm_s[8] = ~use_xnor_s;
    end

    // Stage 1 register: q_m, its ones count, and the aligned DE/control bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qm_r <= 9'd0;
            n1_r <= 4'd0;
            de_r <= 1'b0;
            c_r  <= 2'b00;
        end else begin
            qm_r <= qm_s;
            n1_r <= popcount8(qm_s[7:0]);
            de_r <= de;
            c_r  <= c;
        end
    end

    // Stage 2 combinational: choose inversion to steer disparity toward zero
    always_comb begin
        n1_sx_s   = $signed({1'b0, n1_r});
        // bal_s is N1 - N0; 5-bit wrap is harmless as the result stays in range
        bal_s     = n1_sx_s + n1_sx_s - 5'sd8;
        q_nxt_s   = CTRL_00;
        cnt_nxt_s = cnt_r;
        if (!de_r) begin
            case (c_r)
                2'b00:   q_nxt_s = CTRL_00;
                2'b01:   q_nxt_s = CTRL_01;
                2'b10:   q_nxt_s = CTRL_10;
                2'b11:   q_nxt_s = CTRL_11;
                default: q_nxt_s = CTRL_00;
            endcase
            cnt_nxt_s = 5'sd0;
        end else if ((cnt_r == 5'sd0) || (bal_s == 5'sd0)) begin
            if (qm_r[8]) begin
                q_nxt_s   = {2'b01, qm_r[7:0]};
                cnt_nxt_s = cnt_r + bal_s;
            end else begin
                q_nxt_s   = {2'b10, ~qm_r[7:0]};
                cnt_nxt_s = cnt_r - bal_s;
            end
        end else if (((cnt_r > 5'sd0) && (bal_s > 5'sd0)) ||
                     ((cnt_r < 5'sd0) && (bal_s < 5'sd0))) begin
            q_nxt_s   = {1'b1, qm_r[8], ~qm_r[7:0]};
            cnt_nxt_s = cnt_r - bal_s + (qm_r[8] ? 5'sd2 : 5'sd0);
        end else begin
            q_nxt_s   = {1'b0, qm_r[8], qm_r[7:0]};
            cnt_nxt_s = cnt_r + bal_s - (qm_r[8] ? 5'sd0 : 5'sd2);
        end
    end

    // Stage 2 register: output symbol and running disparity
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= CTRL_00;
            cnt_r <= 5'sd0;
        end else begin
            q     <= q_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// Three-channel TMDS encoder; syncs ride on the blue channel's control bits,
// green and red carry 00 during blanking.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       red_in,
    input  logic [7:0]       green_in,
    input  logic [7:0]       blue_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    output logic [SYM_W-1:0] tmds_blue,
    output logic [SYM_W-1:0] tmds_green,
    output logic [SYM_W-1:0] tmds_red
);

    tmds_channel u_ch0_blue (
        .clk (clk),
        .rst (rst),
        .d   (blue_in),
        .c   ({vsync_in, hsync_in}),
        .de  (de_in),
        .q   (tmds_blue)
    );

    tmds_channel u_ch1_green (
        .clk (clk),
        .rst (rst),
        .d   (green_in),
        .c   (2'b00),
        .de  (de_in),
        .q   (tmds_green)
    );

    tmds_channel u_ch2_red (
        .clk (clk),
        .rst (rst),
        .d   (red_in),
        .c   (2'b00),
        .de  (de_in),
        .q   (tmds_red)
    );

endmodule
